bcd_scan_driver: RTL

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

---
 rtl/bcd_disp_pkg.sv | 22 ++
 rtl/bcd_scan_driver_seg7.sv | 24 ++
 rtl/bcd_scan_driver.sv | 80 ++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared FSM state type, segment patterns and BCD helpers
package bcd_disp_pkg;
  typedef enum logic [2:0] {IDLE, UNITS, GAP_U, TENS, GAP_T} state_t;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [5:0] BCD_INVALID = 6'b11_0000;
  // tens must be 0 or 1 and units 0..9; the decoder default code is never displayable
  function automatic logic bcd_valid(input logic [5:0] v);
    return v != BCD_INVALID && !v[5] && v[3:0] < 4'd10;
  endfunction
endpackage

// File: rtl/bcd_scan_driver_seg7.sv
// seg7_encode: BCD nibble to active-high gfedcba segment pattern
module seg7_encode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  // non-decimal nibbles map to an unlit digit
  always_comb begin
    case (nib_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: two-digit multiplexed 7-segment driver for a latched BCD value
module bcd_scan_driver
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYC = 2,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] bcd_in,
  input  logic       load,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       err
);
  localparam int MAXC = REFRESH_DIV > GAP_CYC ? REFRESH_DIV : GAP_CYC;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] RLD_DIG = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] RLD_GAP = CW'(GAP_CYC - 1);
  state_t state_q, state_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] val_q, val_d;
  logic err_q, err_d, blank_t;
  logic [6:0] seg_n_q, seg_n_d, enc;
  logic [1:0] an_n_q, an_n_d;
  logic [3:0] nib;
  // scan sequencing: one down-counter reloaded on every state entry, move on zero
  always_comb begin
    nxt = state_q == UNITS ? GAP_U : state_q == GAP_U ? TENS : state_q == TENS ? GAP_T : UNITS;
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (load) begin
        state_d = UNITS;
        cnt_d = RLD_DIG;
      end
    end else if (cnt_q == '0) begin
      state_d = nxt;
      cnt_d = (nxt == UNITS || nxt == TENS) ? RLD_DIG : RLD_GAP;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end
  // value capture and display decode use next-state values so a load shows up one cycle later
  always_comb begin
    val_d = load ? bcd_in : val_q;
    err_d = load ? !bcd_valid(bcd_in) : err_q;
    nib = state_d == TENS ? {2'b00, val_d[5:4]} : val_d[3:0];
    blank_t = BLANK_LZ && val_d[5:4] == 2'b00 && !err_d;
    seg_n_d = ~(state_d == UNITS ? (err_d ? SEG_E : enc) :
                state_d == TENS ? (err_d ? SEG_DASH : enc) : SEG_OFF);
    an_n_d = state_d == UNITS ? 2'b10 : (state_d == TENS && !blank_t) ? 2'b01 : 2'b11;
  end
  seg7_encode u_enc (
    .nib_i(nib),
    .seg_o(enc)
  );
  // state, value and registered outputs; async reset blanks the display at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      val_q <= 6'b00_0000;
      err_q <= 1'b0;
      seg_n_q <= 7'h7F;
      an_n_q <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      val_q <= val_d;
      err_q <= err_d;
      seg_n_q <= seg_n_d;
      an_n_q <= an_n_d;
    end
  end
  assign seg_n = seg_n_q;
  assign an_n = an_n_q;
  assign err = err_q;
endmodule
